// File: rtl/adc_sample_conditioner_if.sv
// ============================================================================
// adc_sample_conditioner_if : capture request, ADC bus and conditioned sample
// Rev 1.0
// ============================================================================
`default_nettype none

interface adc_sample_conditioner_if;
  logic        collectData;
  logic        testMode;
  logic [9:0]  adcData;
  logic [15:0] sampleData;
  logic        sampleValid;
  logic        clipFlag;

  modport master (
    output collectData,
    output testMode,
    output adcData,
    input  sampleData,
    input  sampleValid,
    input  clipFlag
  );

  modport slave (
    input  collectData,
    input  testMode,
    input  adcData,
    output sampleData,
    output sampleValid,
    output clipFlag
  );
endinterface

`default_nettype wire

// File: rtl/adc_sample_conditioner.sv
// ============================================================================
// adc_sample_conditioner : ADC-domain capture gate, test ramp, signed
// left-justified sample output and windowed RF clip detection.
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_sample_conditioner #(
  parameter int TEST_WRAP      = 1021,
  parameter int ARM_CYCLES     = 4,
  parameter int CLIP_WINDOW    = 4096,
  parameter int CLIP_THRESHOLD = 16
) (
  input  wire logic               adc_clock,
  input  wire logic               nReset,
  adc_sample_conditioner_if.slave bus
);

  localparam int RAMP_W = $clog2(TEST_WRAP);
  localparam int ARM_W  = $clog2(ARM_CYCLES + 1);
  localparam int WIN_W  = $clog2(CLIP_WINDOW);
  localparam int CLIP_W = $clog2(CLIP_THRESHOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cd_meta_q, cd_sync_q;
  logic                mode_q, mode_d;
  logic [9:0]          adc_q;
  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic [15:0]         sample_q, sample_d;
  logic                valid_q, valid_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [CLIP_W-1:0]   clip_cnt_q, clip_cnt_d;
  logic                clip_flag_q, clip_flag_d;

  logic [15:0]         w_adc_off;
  logic [15:0]         w_adc_conv;
  logic [15:0]         w_ramp_conv;
  logic                w_clipped;
  logic [CLIP_W:0]     w_clip_incl;

  // Offset-binary to two's complement, then left-justify the 10 bits.
  assign w_adc_off   = {6'b0, adc_q} - 16'd512;
  assign w_adc_conv  = w_adc_off << 6;
  assign w_ramp_conv = 16'(ramp_q) << 6;
  assign w_clipped   = (adc_q == 10'd0) || (adc_q == 10'd1023);
  assign w_clip_incl = {1'b0, clip_cnt_q} + (CLIP_W+1)'(w_clipped);

  always_ff @(posedge adc_clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      cd_meta_q   <= 1'b0;
      cd_sync_q   <= 1'b0;
      mode_q      <= 1'b0;
      adc_q       <= '0;
      arm_cnt_q   <= '0;
      ramp_q      <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      win_cnt_q   <= '0;
      clip_cnt_q  <= '0;
      clip_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_meta_q   <= bus.collectData;
      cd_sync_q   <= cd_meta_q;
      mode_q      <= mode_d;
      adc_q       <= bus.adcData;
      arm_cnt_q   <= arm_cnt_d;
      ramp_q      <= ramp_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      win_cnt_q   <= win_cnt_d;
      clip_cnt_q  <= clip_cnt_d;
      clip_flag_q <= clip_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    arm_cnt_d   = arm_cnt_q;
    ramp_d      = ramp_q;
    sample_d    = '0;
    win_cnt_d   = win_cnt_q;
    clip_cnt_d  = clip_cnt_q;
    clip_flag_d = clip_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (cd_sync_q) begin
          state_d   = ST_ARM;
          arm_cnt_d = '0;
          mode_d    = bus.testMode;
          ramp_d    = '0;
        end
      end
      ST_ARM: begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
        if (!cd_sync_q) begin
          state_d = ST_IDLE;
        end else if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!cd_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The sample loaded on this edge is valid exactly while the next state is RUN.
    valid_d = (state_d == ST_RUN);

    if (valid_d) begin
      if (mode_q) begin
        sample_d = w_ramp_conv;
        ramp_d   = (ramp_q == RAMP_W'(TEST_WRAP - 1)) ? '0 : ramp_q + RAMP_W'(1);
      end else begin
        sample_d = w_adc_conv;
        if (win_cnt_q == WIN_W'(CLIP_WINDOW - 1)) begin
          clip_flag_d = (w_clip_incl >= (CLIP_W+1)'(CLIP_THRESHOLD));
          win_cnt_d   = '0;
          clip_cnt_d  = '0;
        end else begin
          win_cnt_d  = win_cnt_q + WIN_W'(1);
          clip_cnt_d = (w_clip_incl >= (CLIP_W+1)'(CLIP_THRESHOLD)) ?
                       CLIP_W'(CLIP_THRESHOLD) : w_clip_incl[CLIP_W-1:0];
        end
      end
    end else if (state_d == ST_IDLE) begin
      win_cnt_d  = '0;
      clip_cnt_d = '0;
    end
  end

  assign bus.sampleData  = sample_q;
  assign bus.sampleValid = valid_q;
  assign bus.clipFlag    = clip_flag_q & ~mode_q;

endmodule

`default_nettype wire
